// File: rtl/page_table_pkg.sv
// Shared widths, FSM state encoding and storage record types for the page table.
package page_table_pkg;
    localparam int VPN_W   = 6;
    localparam int PPN_W   = 2;
    localparam int ENTRIES = 64;
    localparam int RMAP_N  = 1 << PPN_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic             valid;
        logic [PPN_W-1:0] ppn;
    } entry_t;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
    } rmap_t;
endpackage

// File: rtl/page_table_if.sv
// Request/response bundle between a requester (master) and the page table (slave).
interface page_table_if;
    import page_table_pkg::*;

    // req is only sampled while busy is low; one accepted req yields exactly one done pulse.
    logic             req;
    logic             write_to_table;
    logic [VPN_W-1:0] V_addr_PT_in;
    logic [PPN_W-1:0] P_addr_PT_wr;
    logic             busy;
    logic             done;
    logic [PPN_W-1:0] P_addr_PT_out;
    logic             page_fault;
    logic [1:0]       state_dbg;

    modport master (
        output req, write_to_table, V_addr_PT_in, P_addr_PT_wr,
        input  busy, done, P_addr_PT_out, page_fault, state_dbg
    );

    modport slave (
        input  req, write_to_table, V_addr_PT_in, P_addr_PT_wr,
        output busy, done, P_addr_PT_out, page_fault, state_dbg
    );
endinterface

// File: rtl/page_table_rmap.sv
// Reverse map (PPN -> owning VPN) plus the round-robin victim pointer used on faults.
module page_table_rmap
    import page_table_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [PPN_W-1:0] lookup_ppn,
    output rmap_t            lookup_ent,
    output logic [PPN_W-1:0] victim_ppn,
    output rmap_t            victim_ent,
    input  logic             clr_en,
    input  logic [PPN_W-1:0] clr_ppn,
    input  logic             wr_en,
    input  logic [PPN_W-1:0] wr_ppn,
    input  logic [VPN_W-1:0] wr_vpn,
    input  logic             adv_ptr
);
    rmap_t            rmap_q [RMAP_N];
    rmap_t            rmap_d [RMAP_N];
    logic [PPN_W-1:0] ptr_q, ptr_d;

    // Clear is applied before write so a slot being refilled always ends valid.
    always_comb begin
        rmap_d = rmap_q;
        ptr_d  = ptr_q;
        if (clr_en) rmap_d[clr_ppn].valid = 1'b0;
        if (wr_en)  rmap_d[wr_ppn] = '{valid: 1'b1, vpn: wr_vpn};
        if (adv_ptr) ptr_d = ptr_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RMAP_N; i++) rmap_q[i] <= '0;
            ptr_q <= '0;
        end else begin
            rmap_q <= rmap_d;
            ptr_q  <= ptr_d;
        end
    end

    assign lookup_ent = rmap_q[lookup_ppn];
    assign victim_ppn = ptr_q;
    assign victim_ent = rmap_q[ptr_q];
endmodule

// File: rtl/page_table.sv
// 64-entry VPN->PPN table with fixed-latency lookup and round-robin fault allocation.
// Optional PAGE_TABLE_STATS_EN adds saturating read/fault counters.
module page_table
    import page_table_pkg::*;
#(
    parameter int LAT       = 3,
    parameter int FAULT_LAT = 8
) (
    input  logic        clock,
    input  logic        reset,
    page_table_if.slave pt
`ifdef PAGE_TABLE_STATS_EN
    ,
    output logic [15:0] read_count,
    output logic [15:0] fault_count
`endif
);
    localparam int MAXL  = (LAT > FAULT_LAT) ? LAT : FAULT_LAT;
    localparam int CNT_W = (MAXL > 1) ? $clog2(MAXL) : 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic [PPN_W-1:0] ppn_q, ppn_d;
    logic [PPN_W-1:0] out_ppn_q, out_ppn_d;
    logic             out_fault_q, out_fault_d;
    entry_t           table_q [ENTRIES];
    entry_t           table_d [ENTRIES];

    rmap_t            lookup_ent, victim_ent;
    logic [PPN_W-1:0] victim_ppn;
    logic             rm_clr_en, rm_wr_en, rm_adv;
    logic [PPN_W-1:0] rm_clr_ppn, rm_wr_ppn;
    entry_t           cur;

    page_table_rmap u_rmap (
        .clock      (clock),
        .reset      (reset),
        .lookup_ppn (ppn_q),
        .lookup_ent (lookup_ent),
        .victim_ppn (victim_ppn),
        .victim_ent (victim_ent),
        .clr_en     (rm_clr_en),
        .clr_ppn    (rm_clr_ppn),
        .wr_en      (rm_wr_en),
        .wr_ppn     (rm_wr_ppn),
        .wr_vpn     (vpn_q),
        .adv_ptr    (rm_adv)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        vpn_d       = vpn_q;
        ppn_d       = ppn_q;
        out_ppn_d   = out_ppn_q;
        out_fault_d = out_fault_q;
        table_d     = table_q;
        rm_clr_en   = 1'b0;
        rm_clr_ppn  = '0;
        rm_wr_en    = 1'b0;
        rm_wr_ppn   = '0;
        rm_adv      = 1'b0;
        cur         = table_q[vpn_q];

        case (state_q)
            ST_IDLE: begin
                if (pt.req) begin
                    wr_d    = pt.write_to_table;
                    vpn_d   = pt.V_addr_PT_in;
                    ppn_d   = pt.P_addr_PT_wr;
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (wr_q) begin
                    // Keep table and rmap a strict bijection: evict the old owner and old slot.
                    if (lookup_ent.valid && lookup_ent.vpn != vpn_q)
                        table_d[lookup_ent.vpn].valid = 1'b0;
                    if (cur.valid && cur.ppn != ppn_q) begin
                        rm_clr_en  = 1'b1;
                        rm_clr_ppn = cur.ppn;
                    end
                    table_d[vpn_q] = '{valid: 1'b1, ppn: ppn_q};
                    rm_wr_en       = 1'b1;
                    rm_wr_ppn      = ppn_q;
                    out_fault_d    = 1'b0;
                    state_d        = ST_DONE;
                end else if (cur.valid) begin
                    out_ppn_d   = cur.ppn;
                    out_fault_d = 1'b0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d   = CNT_W'(FAULT_LAT - 1);
                    state_d = ST_FAULT;
                end
            end
            ST_FAULT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (victim_ent.valid) table_d[victim_ent.vpn].valid = 1'b0;
                    table_d[vpn_q] = '{valid: 1'b1, ppn: victim_ppn};
                    rm_wr_en       = 1'b1;
                    rm_wr_ppn      = victim_ppn;
                    rm_adv         = 1'b1;
                    out_ppn_d      = victim_ppn;
                    out_fault_d    = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            vpn_q       <= '0;
            ppn_q       <= '0;
            out_ppn_q   <= '0;
            out_fault_q <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            vpn_q       <= vpn_d;
            ppn_q       <= ppn_d;
            out_ppn_q   <= out_ppn_d;
            out_fault_q <= out_fault_d;
            table_q     <= table_d;
        end
    end

    assign pt.busy          = (state_q != ST_IDLE);
    assign pt.done          = (state_q == ST_DONE);
    assign pt.P_addr_PT_out = out_ppn_q;
    assign pt.page_fault    = out_fault_q && (state_q == ST_DONE);
    assign pt.state_dbg     = state_q;

`ifdef PAGE_TABLE_STATS_EN
    logic [15:0] read_cnt_q, read_cnt_d;
    logic [15:0] fault_cnt_q, fault_cnt_d;

    always_comb begin
        read_cnt_d  = read_cnt_q;
        fault_cnt_d = fault_cnt_q;
        if (state_q == ST_DONE && !wr_q) begin
            if (read_cnt_q != 16'hFFFF) read_cnt_d = read_cnt_q + 16'd1;
            if (out_fault_q && fault_cnt_q != 16'hFFFF) fault_cnt_d = fault_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_cnt_q  <= '0;
            fault_cnt_q <= '0;
        end else begin
            read_cnt_q  <= read_cnt_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign read_count  = read_cnt_q;
    assign fault_count = fault_cnt_q;
`endif
endmodule

// File: tb/tb_page_table.sv
// Directed bench for page_table: expected {fault, ppn, latency} records are queued at issue
// and popped when done pulses.
module tb_page_table;
    import page_table_pkg::*;

    localparam int LAT       = 3;
    localparam int FAULT_LAT = 8;
    localparam int T_MAP     = LAT + 1;
    localparam int T_FLT     = LAT + FAULT_LAT + 1;
    localparam int EXP_W     = 11;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [EXP_W-1:0] exp_q[$];

    page_table_if pt();

`ifdef PAGE_TABLE_STATS_EN
    logic [15:0] read_count, fault_count;
`endif

    always #5 clock = ~clock;

    page_table #(.LAT(LAT), .FAULT_LAT(FAULT_LAT)) dut (
        .clock       (clock),
        .reset       (reset),
        .pt          (pt)
`ifdef PAGE_TABLE_STATS_EN
        ,
        .read_count  (read_count),
        .fault_count (fault_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset             = 1'b1;
        pt.req            = 1'b0;
        pt.write_to_table = 1'b0;
        pt.V_addr_PT_in   = '0;
        pt.P_addr_PT_wr   = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // One request; e_ppn on a write is the previous read result, which must be held.
    task automatic op(input string tag, input logic wr, input logic [5:0] vpn,
                      input logic [1:0] wppn, input logic [1:0] e_ppn,
                      input logic e_fault, input int e_lat);
        logic [EXP_W-1:0] e;
        int   cyc;
        logic seen;
        @(negedge clock);
        check({tag, ":idle"}, 32'(pt.busy), 32'd0);
        pt.req            = 1'b1;
        pt.write_to_table = wr;
        pt.V_addr_PT_in   = vpn;
        pt.P_addr_PT_wr   = wppn;
        exp_q.push_back({e_fault, e_ppn, 8'(e_lat)});
        @(posedge clock);
        #1 pt.req = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clock);
            cyc++;
            seen = pt.done;
        end
        e = exp_q.pop_front();
        check({tag, ":lat"}, 32'(cyc), 32'(e[7:0]));
        check({tag, ":fault"}, 32'(pt.page_fault), 32'(e[10]));
        check({tag, ":ppn"}, 32'(pt.P_addr_PT_out), 32'(e[9:8]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones;
        int first_at;
        int cyc;
        logic seen;

        // Reset state
        do_reset();
        @(negedge clock);
        check("rst_busy", 32'(pt.busy), 32'd0);
        check("rst_done", 32'(pt.done), 32'd0);
        check("rst_fault", 32'(pt.page_fault), 32'd0);
        check("rst_ppn", 32'(pt.P_addr_PT_out), 32'd0);
        check("rst_state", 32'(pt.state_dbg), 32'(ST_IDLE));

        // First read faults, repeats hit
        op("rd5_fault", 1'b0, 6'd5, 2'd0, 2'd0, 1'b1, T_FLT);
        op("rd5_hit", 1'b0, 6'd5, 2'd0, 2'd0, 1'b0, T_MAP);
        op("rd5_hit2", 1'b0, 6'd5, 2'd0, 2'd0, 1'b0, T_MAP);
`ifdef PAGE_TABLE_STATS_EN
        @(negedge clock);
        check("stat_reads", 32'(read_count), 32'd3);
        check("stat_faults", 32'(fault_count), 32'd1);
`endif

        // Round-robin victim choice with wrap
        do_reset();
        op("f1", 1'b0, 6'd1, 2'd0, 2'd0, 1'b1, T_FLT);
        op("f2", 1'b0, 6'd2, 2'd0, 2'd1, 1'b1, T_FLT);
        op("f3", 1'b0, 6'd3, 2'd0, 2'd2, 1'b1, T_FLT);
        op("f4", 1'b0, 6'd4, 2'd0, 2'd3, 1'b1, T_FLT);
        op("f9", 1'b0, 6'd9, 2'd0, 2'd0, 1'b1, T_FLT);
        op("h9", 1'b0, 6'd9, 2'd0, 2'd0, 1'b0, T_MAP);
        op("f1_again", 1'b0, 6'd1, 2'd0, 2'd1, 1'b1, T_FLT);
        op("h4", 1'b0, 6'd4, 2'd0, 2'd3, 1'b0, T_MAP);
        op("f2_again", 1'b0, 6'd2, 2'd0, 2'd2, 1'b1, T_FLT);

        // Writes steal mappings and do not move the victim pointer
        do_reset();
        op("w_f1", 1'b0, 6'd1, 2'd0, 2'd0, 1'b1, T_FLT);
        op("w_f2", 1'b0, 6'd2, 2'd0, 2'd1, 1'b1, T_FLT);
        op("w_f3", 1'b0, 6'd3, 2'd0, 2'd2, 1'b1, T_FLT);
        op("wr7_p2", 1'b1, 6'd7, 2'd2, 2'd2, 1'b0, T_MAP);
        op("rd7", 1'b0, 6'd7, 2'd0, 2'd2, 1'b0, T_MAP);
        op("rd3_evicted", 1'b0, 6'd3, 2'd0, 2'd3, 1'b1, T_FLT);
        op("wr7_p0", 1'b1, 6'd7, 2'd0, 2'd3, 1'b0, T_MAP);
        op("rd7_p0", 1'b0, 6'd7, 2'd0, 2'd0, 1'b0, T_MAP);
        op("rd1_evicted", 1'b0, 6'd1, 2'd0, 2'd0, 1'b1, T_FLT);
        op("rd7_evicted", 1'b0, 6'd7, 2'd0, 2'd1, 1'b1, T_FLT);
        op("rd3_hit", 1'b0, 6'd3, 2'd0, 2'd3, 1'b0, T_MAP);
        op("rd2_freeslot", 1'b0, 6'd2, 2'd0, 2'd2, 1'b1, T_FLT);

        // req held high: one done, restart only from the following IDLE cycle
        @(negedge clock);
        pt.req            = 1'b1;
        pt.write_to_table = 1'b0;
        pt.V_addr_PT_in   = 6'd3;
        dones    = 0;
        first_at = 0;
        for (int i = 1; i <= T_MAP; i++) begin
            @(negedge clock);
            if (pt.done) begin
                dones++;
                if (first_at == 0) first_at = i;
            end
        end
        check("hold_dones", 32'(dones), 32'd1);
        check("hold_lat", 32'(first_at), 32'(T_MAP));
        @(negedge clock);
        check("hold_idle_busy", 32'(pt.busy), 32'd0);
        check("hold_idle_done", 32'(pt.done), 32'd0);
        @(negedge clock);
        check("hold_restart", 32'(pt.busy), 32'd1);
        pt.req = 1'b0;
        exp_q.push_back({1'b0, 2'd3, 8'(T_MAP - 1)});
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(negedge clock);
            cyc++;
            seen = pt.done;
        end
        begin
            logic [EXP_W-1:0] e;
            e = exp_q.pop_front();
            check("hold2_lat", 32'(cyc), 32'(e[7:0]));
            check("hold2_ppn", 32'(pt.P_addr_PT_out), 32'(e[9:8]));
        end

        // Reset in the middle of FAULT aborts the operation
        @(negedge clock);
        pt.req            = 1'b1;
        pt.write_to_table = 1'b0;
        pt.V_addr_PT_in   = 6'd40;
        @(posedge clock);
        #1 pt.req = 1'b0;
        repeat (LAT + 2) @(negedge clock);
        check("abort_in_fault", 32'(pt.state_dbg), 32'(ST_FAULT));
        reset = 1'b1;
        #1;
        check("abort_rst_busy", 32'(pt.busy), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (pt.done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        op("abort_rd40", 1'b0, 6'd40, 2'd0, 2'd0, 1'b1, T_FLT);
        op("abort_rd3", 1'b0, 6'd3, 2'd0, 2'd1, 1'b1, T_FLT);
        op("abort_rd40_hit", 1'b0, 6'd40, 2'd0, 2'd0, 1'b0, T_MAP);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/page_table.md
PAGE_TABLE -- requirements
Module: page_table

Interface
REQ-001 Parameter LAT, default 3: cycles from request accept to done for a mapped read or a write (≥1).
REQ-002 Parameter FAULT_LAT, default 8: extra cycles added to a read that page-faults (≥1).
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  1  request valid, sampled only in IDLE.
REQ-006 write_to_table  input  1  1 = write-back of a translation, 0 = read of a translation.
REQ-007 V_addr_PT_in  input  6  VPN of the request.
REQ-008 P_addr_PT_wr  input  2  PPN to store on a write.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse marking completion.
REQ-011 P_addr_PT_out  output  2  PPN for the completed read; holds until the next done.
REQ-012 page_fault  output  1  valid with done; 1 if the completed read faulted.

Function
REQ-013 Storage: 64 entries {valid, PPN[1:0]} indexed by VPN; reverse map of 4 entries {valid, VPN[5:0]} indexed by PPN; 2-bit victim pointer.
REQ-014 FSM states IDLE, WAIT, FAULT, DONE; reset state IDLE.
REQ-015 IDLE and req=1: latch write_to_table, VPN, PPN; load counter with LAT-1; go to WAIT.
REQ-016 req while not IDLE is ignored, not queued; req during DONE is also ignored.
REQ-017 WAIT: decrement counter; at 0, a write or a read of a valid entry goes to DONE; a read of an invalid entry loads FAULT_LAT-1 and goes to FAULT.
REQ-018 Write at WAIT exit: if rmap[PPN] is valid with a different VPN, clear that VPN's entry valid; if the written VPN is already valid with a different PPN, clear the old rmap slot; set table[VPN]={1,PPN}; set rmap[PPN]={1,VPN}.
REQ-019 FAULT at counter 0: victim v = pointer; if rmap[v] is valid, invalidate table[rmap[v].VPN]; install table[VPN]={1,v} and rmap[v]={1,VPN}; pointer increments mod 4 (3 wraps to 0); go to DONE.
REQ-020 DONE, one cycle: done=1; P_addr_PT_out = entry PPN on a read, unchanged on a write; page_fault=1 only after FAULT; then go to IDLE.
REQ-021 Latency from accept edge to done: LAT+1 cycles mapped or write, LAT+FAULT_LAT+1 cycles on a fault.
REQ-022 The victim pointer advances only on faults, never on writes.

Reset
REQ-023 Reset clears all table and rmap valid bits, the pointer, and the counter; done, busy, page_fault and P_addr_PT_out go to 0.
REQ-024 Reset during WAIT or FAULT aborts the operation: no done pulse and no table or rmap update.

Configuration
REQ-025 With PAGE_TABLE_STATS_EN defined, add outputs read_count[15:0] and fault_count[15:0]. They increment on each read done and each faulted done, saturate at 16'hFFFF, and clear on reset.
REQ-026 Without PAGE_TABLE_STATS_EN, these ports and their counters do not exist and behaviour is otherwise identical.

Structure
REQ-027 Package page_table_pkg holds VPN_W=6, PPN_W=2, ENTRIES=64, the FSM state enum and the entry/rmap struct typedefs.
REQ-028 One sub-module, page_table_rmap, holds the reverse map and victim pointer and gives the owner lookup and victim choice.

Verification
REQ-029 After reset, read VPN 5 -> done at LAT+FAULT_LAT+1 cycles, page_fault=1, P_addr_PT_out=0; a repeat read gives PPN 0 at LAT+1 cycles with page_fault=0.
REQ-030 Faults on VPNs 1,2,3,4,9 -> PPNs 0,1,2,3,0; VPN 1 then faults again and is assigned PPN 1.
REQ-031 Write VPN 7 to PPN 2 while VPN 3 holds PPN 2 -> VPN 3 invalid (faults on read); read VPN 7 returns 2 with no fault.
REQ-032 req held high through a whole operation -> exactly one done; a second operation starts only in the IDLE cycle after DONE.
REQ-033 Assert reset in the middle of FAULT -> no done, all entries invalid, pointer=0.
REQ-034 With PAGE_TABLE_STATS_EN, after 3 reads (1 faulting) -> read_count=3, fault_count=1; saturation holds at 16'hFFFF.
